// File: rtl/spi_slave_ctrl_if.sv
// SPI slave controller bus: serial pins toward the SPI master and the
// parallel command/response handshake toward the single-port RAM.
interface spi_slave_ctrl_if #(
    parameter int WORD_W    = 10,
    parameter int ADDR_SIZE = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [WORD_W-1:0]    rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    // Controller side.
    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    // Environment side: SPI master plus RAM.
    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM. Collects a 10-bit command
// word MSB-first from MOSI, hands it to the RAM with a one-cycle rx_valid
// strobe and, on read-data frames, serializes the RAM's byte onto MISO.
module spi_slave_ctrl #(
    parameter int WORD_W    = 10,
    parameter int ADDR_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_slave_ctrl_if.slave    bus
);

    // Counter runs 0..WORD_W while receiving, then on through the transmit
    // phase of a read-data frame, and parks one past the last MISO bit.
    localparam int CNT_W = $clog2(WORD_W + ADDR_SIZE + 2);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] TX_END  = CNT_W'(WORD_W + ADDR_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_W-2:0]    rx_shift;
    logic [ADDR_SIZE-1:0] tx_shift;
    logic [WORD_W-1:0]    rx_data;
    logic                 rx_valid;
    logic                 miso;
    logic                 rd_addr_loaded;

    // Per-edge control decoded from state and counter.
    logic abort;
    logic shift_en;
    logic word_done;
    logic tx_load;
    logic tx_step;
    logic tx_done;

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;

    // State register.
    // NOTE: sequential state is always written with <=, so every flop in this
    // file samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and per-edge control strobes.
    // NOTE: every output of this block gets a default up front so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        tx_load    = 1'b0;
        tx_step    = 1'b0;
        tx_done    = 1'b0;

        if (state != IDLE && bus.SS_n) begin
            abort      = 1'b1;
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.SS_n) state_next = CHK_CMD;
                end
                CHK_CMD: begin
                    // First MOSI bit is word bit 9 and picks the frame type.
                    shift_en = 1'b1;
                    if (!bus.MOSI)           state_next = WRITE;
                    else if (!rd_addr_loaded) state_next = READ_ADD;
                    else                     state_next = READ_DATA;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt < RX_DONE) begin
                        shift_en  = 1'b1;
                        word_done = (cnt == RX_LAST);
                    end else if (state == READ_DATA) begin
                        // Transmit phase; tx_valid only matters while waiting.
                        if (cnt == RX_DONE)      tx_load = bus.tx_valid;
                        else if (cnt < TX_END)   tx_step = 1'b1;
                        else if (cnt == TX_END)  tx_done = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Receive shifter, rx handshake, MISO serializer and read-address flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            miso           <= 1'b0;
            rd_addr_loaded <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                cnt  <= '0;
                miso <= 1'b0;
            end else begin
                if (shift_en) begin
                    rx_shift <= {rx_shift[WORD_W-3:0], bus.MOSI};
                    cnt      <= cnt + 1'b1;
                end
                if (word_done) begin
                    rx_data  <= {rx_shift, bus.MOSI};
                    rx_valid <= 1'b1;
                    // rx_shift still holds bits 9..1, so its top two are [9:8].
                    if (rx_shift[WORD_W-2 -: 2] == 2'b10) rd_addr_loaded <= 1'b1;
                end
                if (tx_load) begin
                    miso     <= bus.tx_data[ADDR_SIZE-1];
                    tx_shift <= {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                end
                if (tx_step) begin
                    miso     <= tx_shift[ADDR_SIZE-1];
                    tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                end
                if (tx_done) begin
                    miso           <= 1'b0;
                    rd_addr_loaded <= 1'b0;
                    cnt            <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: the bench plays SPI master and RAM,
// keeps a command-level model of the RAM and of the read-address flag, and
// checks the controller's strobes and serial output against it.
module tb_spi_slave_ctrl;

    localparam int WORD_W    = 10;
    localparam int ADDR_SIZE = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_slave_ctrl_if #(.WORD_W(WORD_W), .ADDR_SIZE(ADDR_SIZE)) bus ();

    spi_slave_ctrl #(.WORD_W(WORD_W), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: RAM contents/pointers, read-address flag, last word.
    logic [7:0]        m_mem [256];
    logic [7:0]        m_wr_addr;
    logic [7:0]        m_rd_addr;
    bit                m_loaded;
    logic [WORD_W-1:0] m_last_rx;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [9:0] rnd_word;
    int         rnd_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One frame of a full command word. cut_mode 1 aborts (SS_n high) and
    // cut_mode 2 resets after cut_bit MISO bits of a read-data transmit.
    task automatic run_frame(input logic [9:0] word, input int tx_delay, input bit noise,
                             input int cut_mode, input int cut_bit);
        bit         is_rd;
        logic [7:0] rd_byte;
        is_rd   = word[9] && m_loaded;
        rd_byte = 8'h00;

        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'($urandom_range(0, 1));
        for (int i = WORD_W - 1; i >= 0; i--) begin
            @(negedge clk);
            if (i == 0) check("rx_valid before last bit", 32'(bus.rx_valid), 32'd0);
            bus.MOSI = word[i];
            if (noise) begin
                bus.tx_valid = 1'($urandom_range(0, 1));
                bus.tx_data  = 8'($urandom);
            end
        end

        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.MOSI     = 1'($urandom_range(0, 1));
        check("rx_valid pulse", 32'(bus.rx_valid), 32'd1);
        check("rx_data word", 32'(bus.rx_data), 32'(word));
        m_last_rx = word;
        case (word[9:8])
            2'b00: m_wr_addr = word[7:0];
            2'b01: m_mem[m_wr_addr] = word[7:0];
            2'b10: m_rd_addr = word[7:0];
            default: rd_byte = m_mem[m_rd_addr];
        endcase
        if (word[9:8] == 2'b10) m_loaded = 1'b1;

        @(negedge clk);
        check("rx_valid single cycle", 32'(bus.rx_valid), 32'd0);

        if (word[9:8] == 2'b11) begin
            repeat (tx_delay) @(negedge clk);
            check("miso before tx_valid", 32'(bus.MISO), 32'd0);
            bus.tx_valid = 1'b1;
            bus.tx_data  = rd_byte;
            @(negedge clk);
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
            if (is_rd) begin
                for (int b = 7; b >= 0; b--) begin
                    if (cut_mode == 1 && (7 - b) == cut_bit) begin
                        bus.SS_n = 1'b1;
                        @(negedge clk);
                        check("abort miso low", 32'(bus.MISO), 32'd0);
                        check("abort keeps rd_addr_loaded", 32'(dut.rd_addr_loaded), 32'(m_loaded));
                        return;
                    end
                    if (cut_mode == 2 && (7 - b) == cut_bit) begin
                        rst_n = 1'b0;
                        #1;
                        m_loaded  = 1'b0;
                        m_last_rx = '0;
                        check("reset miso", 32'(bus.MISO), 32'd0);
                        check("reset rx_data", 32'(bus.rx_data), 32'(m_last_rx));
                        check("reset rd_addr_loaded", 32'(dut.rd_addr_loaded), 32'(m_loaded));
                        @(negedge clk);
                        bus.SS_n = 1'b1;
                        rst_n    = 1'b1;
                        repeat (3) begin
                            @(negedge clk);
                            check("no rx_valid after reset", 32'(bus.rx_valid), 32'd0);
                        end
                        return;
                    end
                    check("miso data bit", 32'(bus.MISO), 32'(rd_byte[b]));
                    @(negedge clk);
                end
                m_loaded = 1'b0;
                check("miso low after byte", 32'(bus.MISO), 32'd0);
            end else begin
                repeat (9) @(negedge clk);
                check("miso ignores tx_valid", 32'(bus.MISO), 32'd0);
            end
        end

        check("rd_addr_loaded", 32'(dut.rd_addr_loaded), 32'(m_loaded));
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("miso idle", 32'(bus.MISO), 32'd0);
    endtask

    // Frame cut short after nbits command bits.
    task automatic abort_frame(input logic [9:0] word, input int nbits);
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.MOSI = word[9-i];
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort no rx_valid", 32'(bus.rx_valid), 32'd0);
        end
        check("abort rx_data held", 32'(bus.rx_data), 32'(m_last_rx));
        check("abort miso", 32'(bus.MISO), 32'd0);
        check("abort rd_addr_loaded", 32'(dut.rd_addr_loaded), 32'(m_loaded));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        m_wr_addr = 8'h00;
        m_rd_addr = 8'h00;
        m_loaded  = 1'b0;
        m_last_rx = '0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset values.
        repeat (2) @(negedge clk);
        check("reset rx_data", 32'(bus.rx_data), 32'd0);
        check("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset miso", 32'(bus.MISO), 32'd0);
        check("reset rd_addr_loaded", 32'(dut.rd_addr_loaded), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address, write data, read address, read data.
        run_frame(10'h0B5, 0, 1'b0, 0, 0);
        run_frame(10'h1E6, 0, 1'b0, 0, 0);
        run_frame(10'h2B5, 0, 1'b0, 0, 0);
        run_frame(10'h300, 0, 1'b0, 0, 0);

        // Read-data command with no address loaded goes to READ_ADD.
        run_frame(10'h300, 0, 1'b0, 0, 0);

        // Abort after 5 bits, then a clean frame.
        abort_frame(10'h2FF, 5);
        run_frame(10'h0FA, 0, 1'b0, 0, 0);

        // Randomized frames with RAM latency, tx_valid noise and aborts.
        for (int n = 0; n < 60; n++) begin
            rnd_word = 10'($urandom);
            rnd_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_frame(rnd_word, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      rnd_mode, $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) abort_frame(10'($urandom), $urandom_range(0, 9));
        end

        // Reset during a read-data transmit after 3 MISO bits.
        run_frame(10'h2B5, 0, 1'b0, 0, 0);
        run_frame(10'h300, 1, 1'b0, 2, 3);
        run_frame(10'h0FA, 0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave front-end that sequences the single-port synchronous RAM.
- Deserializes 10-bit command words from MOSI and presents each to the RAM as rx_data with a one-cycle rx_valid pulse.
- On read-data frames, captures the RAM's 8-bit response (tx_data/tx_valid) and serializes it MSB-first on MISO.
- Tracks whether a read address has been loaded, which decides the read-frame type.

Parameters:
- WORD_W, 10, command word width: 2 command bits plus ADDR_SIZE payload bits.
- ADDR_SIZE, 8, payload/data width; equals RAM data width.

Ports:
- clk  input  1  system clock; everything samples on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial read data to master, MSB first.
- rx_data  output  WORD_W  assembled command word to RAM din.
- rx_valid  output  1  one-cycle strobe: rx_data is complete.
- tx_data  input  ADDR_SIZE  RAM dout.
- tx_valid  input  1  RAM dout valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rx_data=0, rx_valid=0, MISO=0.
  - rd_addr_loaded=0; bit counter=0; tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Binary encoded, single registered state.
- Edge numbering within a frame: edge 0 is the first rising edge sampling SS_n=0.
- IDLE:
  - SS_n=0 -> CHK_CMD at edge 0. No MOSI sampled.
  - SS_n=1 -> stay in IDLE.
- CHK_CMD: at edge 1, MOSI is sampled as word bit 9 and shifted in.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_loaded=0 -> READ_ADD.
  - MOSI=1 and rd_addr_loaded=1 -> READ_DATA.
- Receive (WRITE, READ_ADD, READ_DATA):
  - Edges 2..10 shift MOSI into bits 8..0.
  - rx_data updates only at edge 10 with the full word.
  - rx_valid=1 for exactly the cycle between edges 10 and 11, then 0.
  - The controller forwards the word unmodified. Bits [9:8] come from the master; the state choice does not alter them.
- rd_addr_loaded:
  - Set at edge 10 when the completed word has [9:8]=2'b10.
  - Cleared when a READ_DATA frame finishes shifting its 8 MISO bits.
  - Unchanged by write frames.
- READ_DATA transmit:
  - After rx_valid, wait for tx_valid=1 (the RAM asserts it the cycle after rx_valid).
  - On the edge sampling tx_valid=1 (edge 12 nominal): load the shift register and drive MISO=tx_data[7].
  - The next 7 edges drive bits 6..0.
  - The following edge drives MISO=0, marks the frame done, and clears rd_addr_loaded.
  - tx_valid outside READ_DATA transmit phase is ignored.
- Post-frame:
  - WRITE/READ_ADD after edge 10, and READ_DATA after transmit, hold state with no further action until SS_n=1.
  - Extra MOSI bits are ignored.
- Abort: SS_n=1 at any edge in any non-IDLE state -> IDLE on that edge.
  - Bit counter cleared; MISO=0.
  - No rx_valid pulse if the word is incomplete.
  - rd_addr_loaded unchanged if READ_DATA is aborted before all 8 MISO bits shift.
- Reset mid-frame: immediate return to reset values; the partial word is discarded.
- MISO is 0 whenever not actively shifting read data.
- Back-to-back frames: SS_n must return high at least one edge between frames; the controller re-enters CHK_CMD from IDLE only.

Test Plan:
- Write address: reset, SS_n low, MOSI 00_10110101 (181) -> rx_valid single pulse after edge 10, rx_data=0x0B5, state returns IDLE on SS_n high, rd_addr_loaded=0.
- Write data: frame 01_11100110 (230) -> rx_data=0x1E6 one-cycle rx_valid; RAM[181]=230.
- Read address then read data:
  - Frame 10_10110101 -> rx_data=0x2B5, rd_addr_loaded=1.
  - Next frame 11_00000000 -> state READ_DATA; tx_valid returns 230; MISO shows 1,1,1,0,0,1,1,0 on consecutive cycles; then MISO=0 and rd_addr_loaded=0.
- Read-data without address: after reset, frame starting MOSI=1 -> READ_ADD chosen (not READ_DATA); rx_data=0x300 forwarded; rd_addr_loaded stays 0.
- Abort: SS_n high after 5 bits -> IDLE next edge, no rx_valid, next full frame 00_11111010 (250) yields rx_data=0x0FA.
- Reset mid-READ_DATA shift (after 3 MISO bits): MISO=0, state IDLE, rd_addr_loaded=0, no further rx_valid.
